// File: rtl/vec_csr_regfile_pkg.sv
// Shared vector-configuration definitions: vtype field layout, LMUL/SEW
// encodings and the CSR update FSM state type.
package vec_csr_regfile_pkg;

  localparam int VLMUL_LSB      = 0;
  localparam int VSEW_LSB       = 3;
  localparam int VTA_BIT        = 6;
  localparam int VMA_BIT        = 7;
  localparam int VTYPE_RSVD_LSB = 8;

  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_F8   = 3'b101,
    LMUL_F4   = 3'b110,
    LMUL_F2   = 3'b111
  } vlmul_e;

  typedef enum logic [2:0] {
    SEW_8  = 3'b000,
    SEW_16 = 3'b001,
    SEW_32 = 3'b010,
    SEW_64 = 3'b011
  } vsew_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    UPDATE = 2'd2
  } csr_state_e;

endpackage

// File: rtl/vec_csr_regfile_if.sv
// Request/response bundle between the vector controller and the vl/vtype CSR stage.
// Handshake: a request is inst_valid & csrwr_en; it is taken on the clock edge
// where csr_ready is also high, and csr_done pulses once when it commits.
interface vec_csr_regfile_if #(
  parameter int XLEN = 32,
  parameter int VLEN = 512
);
  localparam int VW = $clog2(VLEN) + 1;

  logic [XLEN-1:0] vec_inst;
  logic            inst_valid;
  logic            csrwr_en;
  logic            vl_sel;
  logic            vtype_sel;
  logic            rs1rd_de;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            vec_busy;
  logic            csr_ready;
  logic            csr_done;
  logic [XLEN-1:0] rd_wdata;
  logic [XLEN-1:0] csr_vl;
  logic [XLEN-1:0] csr_vtype;
  logic [VW-1:0]   csr_vlmax;

  modport master (
    output vec_inst, inst_valid, csrwr_en, vl_sel, vtype_sel, rs1rd_de,
           rs1_data, rs2_data, vec_busy,
    input  csr_ready, csr_done, rd_wdata, csr_vl, csr_vtype, csr_vlmax
  );

  modport slave (
    input  vec_inst, inst_valid, csrwr_en, vl_sel, vtype_sel, rs1rd_de,
           rs1_data, rs2_data, vec_busy,
    output csr_ready, csr_done, rd_wdata, csr_vl, csr_vtype, csr_vlmax
  );

endinterface

// File: rtl/vec_csr_regfile_vlmax_calc.sv
// Combinational vtype decode: VLMAX, vill, and the vtype value to commit.
// Shift-only so it can sit on the decode-stage forwarding path as well.
module vec_vlmax_calc
  import vec_csr_regfile_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int VLEN = 512,
  parameter  int ELEN = 32,
  localparam int VW   = $clog2(VLEN) + 1
) (
  input  logic [XLEN-1:0] vtype_i,
  output logic [VW-1:0]   vlmax_o,
  output logic            vill_o,
  output logic [XLEN-1:0] vtype_o
);

  logic [2:0]    vsew;
  logic [2:0]    vlmul;
  logic [4:0]    sh;
  logic [VW-1:0] vlen_v;
  logic [VW-1:0] vlmax_raw;
  logic          sew_too_big;
  logic          rsvd_bits;

  always_comb begin
    vsew      = vtype_i[VSEW_LSB +: 3];
    vlmul     = vtype_i[VLMUL_LSB +: 3];
    vlen_v    = VW'(VLEN);
    sh        = 5'd0;
    vlmax_raw = '0;
    // Fractional LMUL folds 1/2^(8-vlmul) into the right shift.
    if (vlmul[2]) begin
      sh        = 5'd3 + 5'(vsew) + (5'd8 - 5'(vlmul));
      vlmax_raw = vlen_v >> sh;
    end else begin
      sh        = 5'd3 + 5'(vsew);
      vlmax_raw = (vlen_v >> sh) << vlmul[1:0];
    end
    sew_too_big = (32'd8 << vsew) > 32'(ELEN);
    rsvd_bits   = |vtype_i[XLEN-2:VTYPE_RSVD_LSB];
    vill_o      = (vlmul == LMUL_RSVD) | vsew[2] | sew_too_big | rsvd_bits |
                  (vlmax_raw == '0);
    vlmax_o     = vill_o ? '0 : vlmax_raw;
    vtype_o     = vill_o ? {1'b1, {(XLEN-1){1'b0}}} : vtype_i;
  end

endmodule

// File: rtl/vec_csr_regfile.sv
// Architectural vl/vtype registers. A vset* request is latched, held in DRAIN
// until in-flight vector work retires, then committed in UPDATE.
module vec_csr_regfile
  import vec_csr_regfile_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int VLEN = 512,
  parameter  int ELEN = 32,
  localparam int VW   = $clog2(VLEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  vec_csr_regfile_if.slave   bus,
  output csr_state_e         dbg_state_o
);

  localparam logic [XLEN-1:0] VTYPE_VILL = {1'b1, {(XLEN-1){1'b0}}};

  csr_state_e      state_q, state_d;
  logic            ready;
  logic            accept;

  logic [4:0]      rd_q;
  logic [4:0]      rs1_q;
  logic [10:0]     zimm_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic            vl_sel_q;
  logic            vtype_sel_q;
  logic            rs1rd_de_q;

  logic [XLEN-1:0] vl_q;
  logic [XLEN-1:0] vtype_q;
  logic [VW-1:0]   vlmax_q;
  logic            done_q;
  logic [XLEN-1:0] rd_wdata_q;

  logic [XLEN-1:0] new_vtype;
  logic [XLEN-1:0] calc_vtype;
  logic [VW-1:0]   calc_vlmax;
  logic            calc_vill;
  logic [XLEN-1:0] vlmax_ext;
  logic [XLEN-1:0] avl;
  logic [XLEN-1:0] new_vl;

  assign ready  = (state_q == IDLE) & ~reset;
  assign accept = bus.inst_valid & bus.csrwr_en & ready;

  // Operands are only valid on the accept cycle, so everything needed later is captured.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q        <= bus.vec_inst[11:7];
      rs1_q       <= bus.vec_inst[19:15];
      zimm_q      <= bus.vec_inst[31] ? {1'b0, bus.vec_inst[29:20]} : bus.vec_inst[30:20];
      rs1_data_q  <= bus.rs1_data;
      rs2_data_q  <= bus.rs2_data;
      vl_sel_q    <= bus.vl_sel;
      vtype_sel_q <= bus.vtype_sel;
      rs1rd_de_q  <= bus.rs1rd_de;
    end
  end

  assign new_vtype = vtype_sel_q ? XLEN'(zimm_q) : rs2_data_q;

  vec_vlmax_calc #(
    .XLEN (XLEN),
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_vlmax_calc (
    .vtype_i (new_vtype),
    .vlmax_o (calc_vlmax),
    .vill_o  (calc_vill),
    .vtype_o (calc_vtype)
  );

  assign vlmax_ext = XLEN'(calc_vlmax);

  always_comb begin
    avl = bus.rs1_data;
    if (vl_sel_q)                         avl = XLEN'(rs1_q);
    else if (!rs1rd_de_q)                 avl = vl_q;
    else if (rs1_q == 5'd0 && rd_q != 5'd0) avl = '1;
    else                                  avl = rs1_data_q;
    new_vl = calc_vill ? '0 : ((avl < vlmax_ext) ? avl : vlmax_ext);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.vec_busy ? DRAIN : UPDATE;
      DRAIN:   if (!bus.vec_busy) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vl_q       <= '0;
      vtype_q    <= VTYPE_VILL;
      vlmax_q    <= '0;
      done_q     <= 1'b0;
      rd_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == UPDATE);
      if (state_q == UPDATE) begin
        vl_q       <= new_vl;
        vtype_q    <= calc_vtype;
        vlmax_q    <= calc_vlmax;
        rd_wdata_q <= new_vl;
      end
    end
  end

  assign bus.csr_ready = ready;
  assign bus.csr_done  = done_q;
  assign bus.rd_wdata  = rd_wdata_q;
  assign bus.csr_vl    = vl_q;
  assign bus.csr_vtype = vtype_q;
  assign bus.csr_vlmax = vlmax_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_vec_csr_regfile.sv
// Directed bench for vec_csr_regfile at VLEN=512, ELEN=32, XLEN=32.
module tb_vec_csr_regfile;
  import vec_csr_regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int VLEN = 512;
  localparam logic [31:0] VILL = 32'h8000_0000;

  logic       clk;
  logic       reset;
  csr_state_e dbg_state;
  int         errors;
  int         checks;

  vec_csr_regfile_if #(.XLEN(XLEN), .VLEN(VLEN)) bus ();

  vec_csr_regfile #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] vsetvli(input logic [10:0] zimm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] vsetivli(input logic [9:0] zimm, input logic [4:0] uimm,
                                           input logic [4:0] rd);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] vsetvl(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [4:0] rd);
    return {1'b1, 6'b0, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.vec_inst   = '0;
    bus.inst_valid = 1'b0;
    bus.csrwr_en   = 1'b0;
    bus.vl_sel     = 1'b0;
    bus.vtype_sel  = 1'b0;
    bus.rs1rd_de   = 1'b0;
    bus.rs1_data   = '0;
    bus.rs2_data   = '0;
  endtask

  // One vset* request without drain; expects done two cycles after accept.
  task automatic run_cfg(input string name, input logic [31:0] inst,
                         input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic vls, input logic vts, input logic de,
                         input logic [31:0] exp_vl, input logic [31:0] exp_vtype,
                         input logic [9:0] exp_vlmax);
    int lat;
    bus.vec_inst   = inst;
    bus.inst_valid = 1'b1;
    bus.csrwr_en   = 1'b1;
    bus.vl_sel     = vls;
    bus.vtype_sel  = vts;
    bus.rs1rd_de   = de;
    bus.rs1_data   = rs1d;
    bus.rs2_data   = rs2d;
    bus.vec_busy   = 1'b0;
    #0;
    checks++;
    if (bus.csr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, bus.csr_ready);
    end
    step();
    clear_inputs();
    lat = 1;
    while (bus.csr_done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL %s latency: got %0d want 2", name, lat);
    end
    checks++;
    if (bus.csr_vl !== exp_vl) begin
      errors++;
      $display("FAIL %s vl: got %0d want %0d", name, bus.csr_vl, exp_vl);
    end
    checks++;
    if (bus.rd_wdata !== exp_vl) begin
      errors++;
      $display("FAIL %s rd_wdata: got %0d want %0d", name, bus.rd_wdata, exp_vl);
    end
    checks++;
    if (bus.csr_vtype !== exp_vtype) begin
      errors++;
      $display("FAIL %s vtype: got %h want %h", name, bus.csr_vtype, exp_vtype);
    end
    checks++;
    if (bus.csr_vlmax !== exp_vlmax) begin
      errors++;
      $display("FAIL %s vlmax: got %0d want %0d", name, bus.csr_vlmax, exp_vlmax);
    end
    step();
    checks++;
    if (bus.csr_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b want 0", name, bus.csr_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.vec_busy = 1'b0;
    step();
    step();
    checks++;
    if (bus.csr_vl !== 32'd0 || bus.csr_vtype !== VILL || bus.csr_vlmax !== 10'd0) begin
      errors++;
      $display("FAIL reset_csr: got vl=%0d vtype=%h vlmax=%0d want 0/%h/0",
               bus.csr_vl, bus.csr_vtype, bus.csr_vlmax, VILL);
    end
    checks++;
    if (bus.csr_done !== 1'b0 || bus.rd_wdata !== 32'd0 || bus.csr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got done=%b rd=%0d ready=%b want 0/0/0",
               bus.csr_done, bus.rd_wdata, bus.csr_ready);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.csr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", bus.csr_ready);
    end
  endtask

  task automatic test_vsetvli();
    run_cfg("e32m1", vsetvli(11'h010, 5'd2, 5'd1), 32'd100, 32'd0, 1'b0, 1'b1, 1'b1,
            32'd16, 32'h010, 10'd16);
    run_cfg("e8m8", vsetvli(11'h003, 5'd2, 5'd1), 32'd100, 32'd0, 1'b0, 1'b1, 1'b1,
            32'd100, 32'h003, 10'd512);
    run_cfg("e8m8_cap", vsetvli(11'h003, 5'd2, 5'd1), 32'd600, 32'd0, 1'b0, 1'b1, 1'b1,
            32'd512, 32'h003, 10'd512);
  endtask

  task automatic test_vsetivli();
    run_cfg("ivli_5", vsetivli(10'h00F, 5'd5, 5'd1), 32'd999, 32'd0, 1'b1, 1'b1, 1'b1,
            32'd5, 32'h00F, 10'd16);
    run_cfg("ivli_31", vsetivli(10'h00F, 5'd31, 5'd1), 32'd999, 32'd0, 1'b1, 1'b1, 1'b1,
            32'd16, 32'h00F, 10'd16);
  endtask

  task automatic test_x0_keep();
    run_cfg("rs1x0", vsetvli(11'h011, 5'd0, 5'd3), 32'd7, 32'd0, 1'b0, 1'b1, 1'b1,
            32'd32, 32'h011, 10'd32);
    run_cfg("keep_vl", vsetvli(11'h008, 5'd0, 5'd0), 32'd7, 32'd0, 1'b0, 1'b1, 1'b0,
            32'd32, 32'h008, 10'd32);
  endtask

  task automatic test_vill();
    run_cfg("vill_keep", vsetvl(5'd4, 5'd2, 5'd1), 32'd100, 32'h004, 1'b0, 1'b0, 1'b0,
            32'd0, VILL, 10'd0);
    run_cfg("vill_rsvd", vsetvl(5'd4, 5'd2, 5'd1), 32'd100, 32'h100, 1'b0, 1'b0, 1'b1,
            32'd0, VILL, 10'd0);
    run_cfg("vill_e64", vsetvli(11'h018, 5'd2, 5'd1), 32'd100, 32'd0, 1'b0, 1'b1, 1'b1,
            32'd0, VILL, 10'd0);
  endtask

  task automatic test_ignore_noncfg();
    int dones;
    dones = 0;
    bus.vec_inst   = vsetvli(11'h003, 5'd2, 5'd1);
    bus.inst_valid = 1'b1;
    bus.csrwr_en   = 1'b0;
    bus.rs1_data   = 32'd50;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.csr_done === 1'b1) dones++;
    end
    clear_inputs();
    checks++;
    if (dones !== 0 || bus.csr_vl !== 32'd0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL noncfg: got dones=%0d vl=%0d state=%0d want 0/0/IDLE",
               dones, bus.csr_vl, dbg_state);
    end
  endtask

  task automatic test_back_to_back_drain();
    int lat;
    int dones;
    bus.vec_inst   = vsetvli(11'h010, 5'd2, 5'd1);
    bus.inst_valid = 1'b1;
    bus.csrwr_en   = 1'b1;
    bus.vtype_sel  = 1'b1;
    bus.rs1rd_de   = 1'b1;
    bus.rs1_data   = 32'd9;
    bus.vec_busy   = 1'b1;
    step();
    lat = 1;
    checks++;
    if (bus.csr_ready !== 1'b0 || dbg_state !== DRAIN) begin
      errors++;
      $display("FAIL drain_ready: got ready=%b state=%0d want 0/DRAIN",
               bus.csr_ready, dbg_state);
    end
    // Competing request while busy must not be taken.
    bus.vec_inst = vsetvli(11'h003, 5'd2, 5'd1);
    bus.rs1_data = 32'd3;
    step();
    lat++;
    clear_inputs();
    bus.vec_busy = 1'b1;
    step();
    lat++;
    bus.vec_busy = 1'b0;
    while (bus.csr_done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL drain_latency: got %0d want 5", lat);
    end
    checks++;
    if (bus.csr_vl !== 32'd9 || bus.csr_vtype !== 32'h010 || bus.csr_vlmax !== 10'd16) begin
      errors++;
      $display("FAIL drain_result: got vl=%0d vtype=%h vlmax=%0d want 9/010/16",
               bus.csr_vl, bus.csr_vtype, bus.csr_vlmax);
    end
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.csr_done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || bus.csr_vl !== 32'd9) begin
      errors++;
      $display("FAIL second_ignored: got dones=%0d vl=%0d want 0/9", dones, bus.csr_vl);
    end
  endtask

  task automatic test_reset_in_drain();
    int dones;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.vec_inst   = vsetvli(11'h010, 5'd2, 5'd1);
    bus.inst_valid = 1'b1;
    bus.csrwr_en   = 1'b1;
    bus.vtype_sel  = 1'b1;
    bus.rs1rd_de   = 1'b1;
    bus.rs1_data   = 32'd9;
    bus.vec_busy   = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (dbg_state !== DRAIN) begin
      errors++;
      $display("FAIL rst_drain_entry: got %0d want DRAIN", dbg_state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.vec_busy = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.csr_done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || bus.csr_vl !== 32'd0 || bus.csr_vtype !== VILL || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL rst_abort: got dones=%0d vl=%0d vtype=%h state=%0d want 0/0/%h/IDLE",
               dones, bus.csr_vl, bus.csr_vtype, dbg_state, VILL);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ignore_noncfg();
    test_vsetvli();
    test_vsetivli();
    test_x0_keep();
    test_vill();
    test_back_to_back_drain();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_csr_regfile.md
Name: vec_csr_regfile

Overview:
Vector configuration CSR stage, directly downstream of vec_processor_controller. Consumes the controller's csrwr_en/vl_sel/vtype_sel/rs1rd_de strobes plus scalar operands. It computes VLMAX and the new vl, validates vtype, and holds the architectural vl/vtype registers. Updates are serialised behind in-flight vector work through a small drain FSM with a valid/ready request handshake and a done pulse that returns rd data to the scalar core.

Parameters:
XLEN, 32, scalar/CSR width
VLEN, 512, vector register length in bits (power of 2, >= 64)
ELEN, 32, max supported SEW in bits (8, 16, 32 or 64)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
vec_inst  in  XLEN  current vector instruction (rd [11:7], rs1/uimm [19:15], zimm [30:20] or [29:20])
inst_valid  in  1  vec_inst and operands valid this cycle
csrwr_en  in  1  from controller: instruction is a vset* config write
vl_sel  in  1  1 = AVL from uimm (vsetivli), 0 = AVL from rs1_data
vtype_sel  in  1  1 = vtype from zimm, 0 = vtype from rs2_data (vsetvl)
rs1rd_de  in  1  0 = rs1=x0 and rd=x0: keep current vl
rs1_data  in  XLEN  scalar rs1 value
rs2_data  in  XLEN  scalar rs2 value
vec_busy  in  1  vector ops still in flight
csr_ready  out  1  request may be accepted
csr_done  out  1  one-cycle pulse: update committed
rd_wdata  out  XLEN  new vl, zero-extended, valid with csr_done
csr_vl  out  XLEN  architectural vl
csr_vtype  out  XLEN  architectural vtype (vill at bit XLEN-1)
csr_vlmax  out  $clog2(VLEN)+1  VLMAX for current vtype

Behaviour:
- Request: req = inst_valid & csrwr_en; accepted when req & csr_ready. csr_ready = (state==IDLE) & ~reset.
- Accept cycle: latch vec_inst fields, rs1_data, rs2_data, and the strobes. Inputs are don't-care afterwards.
- FSM IDLE -> (accept & vec_busy) DRAIN | (accept & ~vec_busy) UPDATE. DRAIN -> UPDATE on the first cycle with ~vec_busy. UPDATE -> IDLE unconditionally.
- UPDATE writes vl/vtype at its clock edge. csr_done, rd_wdata and the new csr_vl/csr_vtype are all visible in the following cycle.
- Latency without drain: accept at cycle N, csr_done at N+2. Each vec_busy cycle in DRAIN adds 1.
- New vtype = vtype_sel ? zero-extended zimm (vec_inst[30:20] for vsetvli, vec_inst[29:20] for vsetivli, selected by bit 31) : rs2_data.
- vill is set if any of the following holds:
  - vlmul==3'b100;
  - SEW=8<<vsew exceeds ELEN;
  - vsew[2]=1;
  - any bit [XLEN-2:8] is nonzero;
  - fractional LMUL gives VLMAX < 1.
- VLMAX = VLEN >> (3+vsew) << vlmul for vlmul 0..3; VLEN >> (3+vsew+(8-vlmul)) for vlmul 5..7. Computed with shifts only, no divider.
- AVL source, in priority order:
  - vl_sel=1: uimm vec_inst[19:15];
  - rs1rd_de=0: keep current vl;
  - rs1 field==0 and rd!=0: AVL = all-ones, so vl = VLMAX;
  - otherwise rs1_data.
- New vl = min(AVL, VLMAX) with an unsigned XLEN-wide compare.
- If vill: vl=0 and csr_vtype = 1<<(XLEN-1). This overrides the keep-vl case.
- rd_wdata = new vl even when rd=x0; the scalar side discards it.
- Reset: csr_vl=0, csr_vtype=1<<(XLEN-1) (vill), csr_vlmax=0, csr_done=0, rd_wdata=0, state=IDLE. Reset during DRAIN/UPDATE aborts the request: no write, no done.
- Non-config instructions (csrwr_en=0) are ignored in every state.

Decomposition:
- vec_csr_pkg (shared, alongside vec_de_csr_defs.svh): vtype field offsets, vlmul/vsew encodings, and the csr_state_e enum {IDLE, DRAIN, UPDATE}.
- Sub-module vec_vlmax_calc: combinational vtype -> {vlmax, vill}. Reused by the decode stage for vsetvl forwarding.

Test Plan:
- VLEN=512. vsetvli rs1_data=100, zimm e32/m1 (0x010), rd=1 -> csr_done at N+2, vl=16, csr_vlmax=16, rd_wdata=16.
- vsetvli rs1_data=100, e8/m8 (0x003) -> vl=100, vlmax=512. Repeat with rs1_data=600 -> vl=512.
- vsetivli uimm=5, e16/mf2 (0x00F) -> vlmax=16, vl=5. Same with uimm=31 -> vl=16.
- vsetvl rs2_data=0x004 (vlmul reserved) -> vl=0, csr_vtype=0x8000_0000, rd_wdata=0. rs2_data=0x100 (reserved bit) -> same.
- rs1=x0, rd=3, e32/m2 -> vl=32. Then rs1rd_de=0 with e16/m1 -> vl stays 32, vtype updated.
- vec_busy held 3 cycles at accept -> csr_ready=0 and a second request is ignored; csr_done at N+5. Reset asserted in DRAIN -> no csr_done, vl unchanged at 0.
